// File: rtl/ic74hc151_scan_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ic74hc151_scan_ctrl_if                              |
// | Description : Bundle between the scan sequencer, its controlling |
// |               logic and the 74HC151 mux it drives.               |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
interface ic74hc151_scan_ctrl_if #(
  parameter int DATA_SelectPart  = 3,
  parameter int DATA_Single_Part = 8
);
  // Requests from the controlling logic
  logic                        Start;
  logic                        Mode;
  logic [DATA_SelectPart-1:0]  Chan;
  // Mux outputs returned to the sequencer
  logic                        Y_In;
  logic                        YF_In;
  // Mux controls driven by the sequencer
  logic                        EN_Part;
  logic [DATA_SelectPart-1:0]  SelectPart;
  // Status and results
  logic                        Busy;
  logic                        Done;
  logic [DATA_Single_Part-1:0] Data_Out;
  logic                        Err;

  // Sequencer side
  modport slave (
    input  Start, Mode, Chan, Y_In, YF_In,
    output EN_Part, SelectPart, Busy, Done, Data_Out, Err
  );

  // Controller and mux side
  modport master (
    output Start, Mode, Chan, Y_In, YF_In,
    input  EN_Part, SelectPart, Busy, Done, Data_Out, Err
  );
endinterface
`default_nettype wire

// File: rtl/ic74hc151_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ic74hc151_scan_ctrl                                 |
// | Description : Drives enable/select of a 74HC151 mux, holds each  |
// |               select for SETTLE_CYCLES, samples Y/YF and packs   |
// |               the samples into a parallel word (full or single). |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module ic74hc151_scan_ctrl #(
  parameter int DATA_SelectPart  = 3,
  parameter int DATA_Single_Part = 8,
  parameter int SETTLE_CYCLES    = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  ic74hc151_scan_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter is wide enough for the largest legal settle time (15)
  localparam int                       CNT_W      = 4;
  localparam logic [CNT_W-1:0]         c_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DATA_SelectPart-1:0] c_SEL_LAST = {DATA_SelectPart{1'b1}};

  state_t                      state_q,   state_d;
  logic [DATA_SelectPart-1:0]  sel_q,     sel_d;
  logic [CNT_W-1:0]            cnt_q,     cnt_d;
  logic                        mode_q,    mode_d;
  logic [DATA_Single_Part-1:0] shadow_q,  shadow_d;
  logic                        err_acc_q, err_acc_d;
  logic [DATA_Single_Part-1:0] data_q,    data_d;
  logic                        err_q,     err_d;

  logic w_sample;
  logic w_err_bit;

  assign w_sample  = (cnt_q == c_CNT_LAST);
  // A healthy mux always presents complementary Y/YF
  assign w_err_bit = (bus.Y_In == bus.YF_In);

  // State and datapath registers; reset discards any partial scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      shadow_q  <= '0;
      err_acc_q <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      shadow_q  <= shadow_d;
      err_acc_q <= err_acc_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: settle, sample, advance select, publish on completion
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    shadow_d  = shadow_q;
    err_acc_d = err_acc_q;
    data_d    = data_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d   = S_SETTLE;
          mode_d    = bus.Mode;
          sel_d     = bus.Mode ? bus.Chan : '0;
          cnt_d     = '0;
          shadow_d  = '0;
          err_acc_d = 1'b0;
        end
      end

      S_SETTLE: begin
        if (w_sample) begin
          cnt_d            = '0;
          shadow_d[sel_q]  = bus.Y_In;
          err_acc_d        = err_acc_q | w_err_bit;
          // Last sample of the operation: results include this sample
          if (mode_q || (sel_q == c_SEL_LAST)) begin
            state_d = S_DONE;
            data_d  = shadow_d;
            err_d   = err_acc_d;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Mux is only enabled while a select is settling or being sampled
  assign bus.EN_Part    = (state_q != S_SETTLE);
  assign bus.SelectPart = sel_q;
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.Done       = (state_q == S_DONE);
  assign bus.Data_Out   = data_q;
  assign bus.Err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ic74hc151_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_ic74hc151_scan_ctrl                              |
// | Description : Self-checking bench for the 74HC151 scan sequencer |
// |               with a behavioural mux model.                      |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_ic74hc151_scan_ctrl;

  localparam int SEL_W = 3;
  localparam int NCH   = 8;
  localparam int SC    = 2;

  logic clk;
  logic rst;
  logic [NCH-1:0] mux_in;
  int             force_ch;

  int n_tests;
  int n_fail;

  ic74hc151_scan_ctrl_if #(.DATA_SelectPart(SEL_W), .DATA_Single_Part(NCH)) bus ();

  ic74hc151_scan_ctrl #(
    .DATA_SelectPart (SEL_W),
    .DATA_Single_Part(NCH),
    .SETTLE_CYCLES   (SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 74HC151 model: Y forced low when disabled, YF normally the complement
  assign bus.Y_In  = bus.EN_Part ? 1'b0 : mux_in[bus.SelectPart];
  assign bus.YF_In = (force_ch >= 0 && !bus.EN_Part && int'(bus.SelectPart) == force_ch)
                     ? bus.Y_In : ~bus.Y_In;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation from an IDLE negedge; measures latency, busy length and
  // checks select/enable sequencing and the quiet period afterwards.
  task automatic run_op(input logic mode, input logic [SEL_W-1:0] chan,
                        input logic [NCH-1:0] mux, input int pa, input int pb,
                        input int idle_watch,
                        output logic [NCH-1:0] dout, output logic err,
                        output int lat, output int busy_cyc, output bit seq_ok);
    int exp_sel;
    bus.Start = 1'b1;
    bus.Mode  = mode;
    bus.Chan  = chan;
    mux_in    = mux;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Mode  = ~mode;
    bus.Chan  = SEL_W'($urandom);
    lat = -1; busy_cyc = 0; seq_ok = 1'b1;
    for (int j = 0; j < 200; j++) begin
      if (j > 0) @(negedge clk);
      bus.Start = (j == pa) || (j == pb);
      if (bus.Busy) busy_cyc++;
      if (bus.Done) begin
        lat = j;
        break;
      end
      exp_sel = mode ? int'(chan) : j / SC;
      if (int'(bus.SelectPart) != exp_sel || bus.EN_Part !== 1'b0 || bus.Busy !== 1'b1)
        seq_ok = 1'b0;
    end
    if (lat >= 0 && bus.EN_Part !== 1'b1) seq_ok = 1'b0;
    @(negedge clk);
    bus.Start = 1'b0;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.EN_Part !== 1'b1 || bus.SelectPart !== '0)
      seq_ok = 1'b0;
    for (int k = 0; k < idle_watch; k++) begin
      @(negedge clk);
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) seq_ok = 1'b0;
    end
    dout = bus.Data_Out;
    err  = bus.Err;
  endtask

  typedef struct {
    logic             mode;
    logic [SEL_W-1:0] chan;
    logic [NCH-1:0]   mux;
    int               fch;
    logic [NCH-1:0]   exp_data;
    logic             exp_err;
    int               exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [NCH-1:0] dout;
    logic           err;
    int             lat, bcyc;
    bit             sok;
    logic           m;
    logic [SEL_W-1:0] c;
    logic [NCH-1:0] x;
    int             f;
    logic [NCH-1:0] ref_data;
    logic           ref_err;
    int             ref_lat;
    int             bad_done, bad_busy, n_done;
    bit             quiet;

    n_tests = 0; n_fail = 0;
    vecs[0] = '{1'b0, 3'd0, 8'hA5, -1, 8'hA5, 1'b0, 16};
    vecs[1] = '{1'b1, 3'd5, 8'h20, -1, 8'h20, 1'b0, 2};
    vecs[2] = '{1'b1, 3'd5, 8'hDF, -1, 8'h00, 1'b0, 2};
    vecs[3] = '{1'b0, 3'd0, 8'hFF,  3, 8'hFF, 1'b1, 16};
    vecs[4] = '{1'b0, 3'd0, 8'h3C, -1, 8'h3C, 1'b0, 16};
    vecs[5] = '{1'b1, 3'd0, 8'h01, -1, 8'h01, 1'b0, 2};
    vecs[6] = '{1'b1, 3'd7, 8'h80, -1, 8'h80, 1'b0, 2};
    vecs[7] = '{1'b1, 3'd7, 8'h7F, -1, 8'h00, 1'b0, 2};
    vecs[8] = '{1'b1, 3'd2, 8'h04,  2, 8'h04, 1'b1, 2};
    vecs[9] = '{1'b0, 3'd6, 8'h00, -1, 8'h00, 1'b0, 16};

    rst = 1'b1; bus.Start = 1'b0; bus.Mode = 1'b0; bus.Chan = '0;
    mux_in = '0; force_ch = -1;
    @(negedge clk);
    @(negedge clk);
    check("reset_en",   32'(bus.EN_Part),    32'd1);
    check("reset_sel",  32'(bus.SelectPart), 32'd0);
    check("reset_busy", 32'(bus.Busy),       32'd0);
    check("reset_done", 32'(bus.Done),       32'd0);
    check("reset_data", 32'(bus.Data_Out),   32'd0);
    check("reset_err",  32'(bus.Err),        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table
    foreach (vecs[i]) begin
      force_ch = vecs[i].fch;
      run_op(vecs[i].mode, vecs[i].chan, vecs[i].mux, -1, -1, 2, dout, err, lat, bcyc, sok);
      force_ch = -1;
      check($sformatf("vec%0d_data", i), 32'(dout), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_err", i),  32'(err),  32'(vecs[i].exp_err));
      check($sformatf("vec%0d_lat", i),  32'(lat),  32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_busy", i), 32'(bcyc), 32'(vecs[i].exp_lat + 1));
      check($sformatf("vec%0d_seq", i),  32'(sok),  32'd1);
    end

    // Start pulses while busy (mid-settle and during DONE) are dropped
    run_op(1'b0, 3'd0, 8'h96, 4, 16, 20, dout, err, lat, bcyc, sok);
    check("busy_start_data", 32'(dout), 32'h96);
    check("busy_start_lat",  32'(lat),  32'd16);
    check("busy_start_seq",  32'(sok),  32'd1);

    // Reset in the middle of a full scan
    bus.Start = 1'b1; bus.Mode = 1'b0; bus.Chan = '0; mux_in = 8'hA5;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_en",   32'(bus.EN_Part),    32'd1);
    check("midrst_sel",  32'(bus.SelectPart), 32'd0);
    check("midrst_busy", 32'(bus.Busy),       32'd0);
    check("midrst_data", 32'(bus.Data_Out),   32'd0);
    check("midrst_err",  32'(bus.Err),        32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) quiet = 1'b0;
    end
    check("midrst_quiet", 32'(quiet), 32'd1);
    run_op(1'b0, 3'd0, 8'h5A, -1, -1, 2, dout, err, lat, bcyc, sok);
    check("postrst_data", 32'(dout), 32'h5A);
    check("postrst_lat",  32'(lat),  32'd16);

    // Start held high: back-to-back scans separated by one IDLE cycle
    bus.Start = 1'b1; bus.Mode = 1'b0; mux_in = 8'hC3;
    bad_done = 0; bad_busy = 0; n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.Done) n_done++;
      if (bus.Done !== ((k % (8*SC + 2)) == 8*SC))     bad_done++;
      if (bus.Busy !== ((k % (8*SC + 2)) != 8*SC + 1)) bad_busy++;
    end
    bus.Start = 1'b0;
    check("held_done_pattern", 32'(bad_done), 32'd0);
    check("held_busy_pattern", 32'(bad_busy), 32'd0);
    check("held_done_count",   32'(n_done),   32'd2);
    check("held_data",         32'(bus.Data_Out), 32'hC3);
    quiet = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.Busy) begin
        quiet = 1'b1;
        break;
      end
    end
    check("held_drain", 32'(quiet), 32'd1);
    @(negedge clk);

    // Randomised operations against a rule-level model
    for (int t = 0; t < 30; t++) begin
      m = 1'($urandom_range(0, 1));
      c = SEL_W'($urandom);
      x = NCH'($urandom);
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NCH-1)) : -1;
      ref_data = m ? (x & (8'd1 << c)) : x;
      ref_err  = (f >= 0) && (!m || f == int'(c));
      ref_lat  = m ? SC : NCH * SC;
      force_ch = f;
      run_op(m, c, x, -1, -1, 1, dout, err, lat, bcyc, sok);
      force_ch = -1;
      check($sformatf("rnd%0d_data", t), 32'(dout), 32'(ref_data));
      check($sformatf("rnd%0d_err", t),  32'(err),  32'(ref_err));
      check($sformatf("rnd%0d_lat", t),  32'(lat),  32'(ref_lat));
      check($sformatf("rnd%0d_seq", t),  32'(sok),  32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
